// File: rtl/mpr_port_ctrl.sv
// rtl/mpr_port_ctrl.sv - two-port memory request controller with same-address collision deferral
module mpr_port_ctrl #(
    parameter int bits = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_a,
    output logic            req_ready_a,
    input  logic            req_we_a,
    input  logic [2:0]      req_addr_a,
    input  logic [bits-1:0] req_wdata_a,
    output logic            rsp_valid_a,
    input  logic            rsp_ready_a,
    output logic [bits-1:0] rsp_data_a,
    output logic            mem_we_a,
    output logic [2:0]      mem_addr_a,
    output logic [bits-1:0] mem_d_a,
    input  logic [bits-1:0] mem_q_a,
    input  logic            req_valid_b,
    output logic            req_ready_b,
    input  logic            req_we_b,
    input  logic [2:0]      req_addr_b,
    input  logic [bits-1:0] req_wdata_b,
    output logic            rsp_valid_b,
    input  logic            rsp_ready_b,
    output logic [bits-1:0] rsp_data_b,
    output logic            mem_we_b,
    output logic [2:0]      mem_addr_b,
    output logic [bits-1:0] mem_d_b,
    input  logic [bits-1:0] mem_q_b,
    output logic [7:0]      coll_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RSP} state_t;

    state_t          state    [2];
    logic            iss_we   [2];
    logic [2:0]      iss_addr [2];
    logic [bits-1:0] iss_data [2];
    logic [bits-1:0] rsp_data [2];

    logic [1:0]      req_valid, req_we, rsp_ready, defer, issue, ready, accept;
    logic [2:0]      req_addr  [2];
    logic [bits-1:0] req_wdata [2];
    logic [bits-1:0] mem_q     [2];
    logic            coll;

    assign req_valid    = {req_valid_b, req_valid_a};
    assign req_we       = {req_we_b, req_we_a};
    assign rsp_ready    = {rsp_ready_b, rsp_ready_a};
    assign req_addr[0]  = req_addr_a;
    assign req_addr[1]  = req_addr_b;
    assign req_wdata[0] = req_wdata_a;
    assign req_wdata[1] = req_wdata_b;
    assign mem_q[0]     = mem_q_a;
    assign mem_q[1]     = mem_q_b;

    // A same-address pair involving a write: A wins unless A is the reader, so writes land A-then-B
    // and any read lands after the write.
    assign coll = (state[0] == ISSUE) && (state[1] == ISSUE) &&
                  (iss_addr[0] == iss_addr[1]) && (iss_we[0] || iss_we[1]);
    assign defer[0] = coll && !iss_we[0];
    assign defer[1] = coll && iss_we[0];

    always_comb begin
        issue  = '0;
        ready  = '0;
        accept = '0;
        for (int i = 0; i < 2; i++) begin
            issue[i]  = (state[i] == ISSUE) && !defer[i];
            ready[i]  = rst_n && ((state[i] == IDLE) || (issue[i] && iss_we[i]));
            accept[i] = req_valid[i] && ready[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i]    <= IDLE;
                iss_we[i]   <= 1'b0;
                iss_addr[i] <= '0;
                iss_data[i] <= '0;
                rsp_data[i] <= '0;
            end
            coll_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    iss_we[i]   <= req_we[i];
                    iss_addr[i] <= req_addr[i];
                    iss_data[i] <= req_wdata[i];
                end
                case (state[i])
                    IDLE:   if (accept[i]) state[i] <= ISSUE;
                    ISSUE:  if (issue[i]) state[i] <= !iss_we[i] ? RDWAIT : (accept[i] ? ISSUE : IDLE);
                    RDWAIT: begin
                        state[i]    <= RSP;
                        rsp_data[i] <= mem_q[i];
                    end
                    RSP:    if (rsp_ready[i]) state[i] <= IDLE;
                endcase
            end
            if ((|defer) && (coll_cnt != 8'hff)) coll_cnt <= coll_cnt + 8'd1;
        end
    end

    assign req_ready_a = ready[0];
    assign req_ready_b = ready[1];
    assign rsp_valid_a = (state[0] == RSP);
    assign rsp_valid_b = (state[1] == RSP);
    assign rsp_data_a  = rsp_data[0];
    assign rsp_data_b  = rsp_data[1];
    assign mem_we_a    = issue[0] && iss_we[0];
    assign mem_we_b    = issue[1] && iss_we[1];
    assign mem_addr_a  = iss_addr[0];
    assign mem_addr_b  = iss_addr[1];
    assign mem_d_a     = iss_data[0];
    assign mem_d_b     = iss_data[1];
endmodule

// File: tb/tb_mpr_port_ctrl.sv
// tb/tb_mpr_port_ctrl.sv - scoreboard bench for mpr_port_ctrl with a synchronous-read memory model
module tb_mpr_port_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_ready_a, req_we_a, rsp_valid_a, rsp_ready_a, mem_we_a;
    logic [2:0]  req_addr_a, mem_addr_a;
    logic [31:0] req_wdata_a, rsp_data_a, mem_d_a, mem_q_a;
    logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, mem_we_b;
    logic [2:0]  req_addr_b, mem_addr_b;
    logic [31:0] req_wdata_b, rsp_data_b, mem_d_b, mem_q_b;
    logic [7:0]  coll_cnt;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          run_a = 0, max_a = 0, wcnt_a = 0;
    logic        hold_b = 1'b0;
    logic [31:0] mem [8];
    logic [31:0] exp_mem [8];
    logic [31:0] exp_q_a [$];
    logic [31:0] exp_q_b [$];
    int          lat_q_a [$];
    int          lat_q_b [$];

    mpr_port_ctrl #(.bits(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a), .rsp_valid_a(rsp_valid_a),
        .rsp_ready_a(rsp_ready_a), .rsp_data_a(rsp_data_a), .mem_we_a(mem_we_a),
        .mem_addr_a(mem_addr_a), .mem_d_a(mem_d_a), .mem_q_a(mem_q_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b), .rsp_valid_b(rsp_valid_b),
        .rsp_ready_b(rsp_ready_b), .rsp_data_b(rsp_data_b), .mem_we_b(mem_we_b),
        .mem_addr_b(mem_addr_b), .mem_d_b(mem_d_b), .mem_q_b(mem_q_b),
        .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request per enabled port and holds it until accepted; the expected-memory model
    // applies A's write, then B's write, then serves same-cycle reads with the newest data.
    task automatic do_pair(input logic va, input logic wa, input logic [2:0] aa, input logic [31:0] da,
                           input int la, input logic vb, input logic wb, input logic [2:0] ab,
                           input logic [31:0] db, input int lb);
        logic pa, pb, xa, xb;
        int   n;
        pa = va; pb = vb; n = 0;
        req_valid_a = va; req_we_a = wa; req_addr_a = aa; req_wdata_a = da;
        req_valid_b = vb; req_we_b = wb; req_addr_b = ab; req_wdata_b = db;
        while ((pa || pb) && n < 50) begin
            xa = pa && req_ready_a;
            xb = pb && req_ready_b;
            if (xa && wa) exp_mem[aa] = da;
            if (xb && wb) exp_mem[ab] = db;
            if (xa && !wa) begin exp_q_a.push_back(exp_mem[aa]); lat_q_a.push_back(cyc + la); end
            if (xb && !wb) begin exp_q_b.push_back(exp_mem[ab]); lat_q_b.push_back(cyc + lb); end
            step();
            n++;
            if (xa) begin pa = 1'b0; req_valid_a = 1'b0; end
            if (xb) begin pb = 1'b0; req_valid_b = 1'b0; end
        end
        if (pa || pb) check("req_timeout", 32'd1, 32'd0);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check("drain_timeout", 32'd1, 32'd0);
        repeat (2) step();
    endtask

    initial begin
        logic [31:0] qa, qb;
        for (int i = 0; i < 8; i++) begin mem[i] = '0; exp_mem[i] = '0; end
        mem_q_a = '0;
        mem_q_b = '0;
        forever begin
            @(posedge clk);
            qa = mem[mem_addr_a];
            qb = mem[mem_addr_b];
            if (mem_we_a) mem[mem_addr_a] = mem_d_a;
            if (mem_we_b) mem[mem_addr_b] = mem_d_b;
            mem_q_a <= qa;
            mem_q_b <= qb;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int w;
        w = 0;
        rsp_ready_b = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!hold_b) rsp_ready_b = 1'b1;
            else if (rsp_valid_b) begin
                if (w == 2) begin rsp_ready_b = 1'b1; w = 0; end
                else begin rsp_ready_b = 1'b0; w++; end
            end else begin
                rsp_ready_b = 1'b0;
                w = 0;
            end
        end
    end

    initial begin
        logic        pva, pra, pvb, prb;
        logic [31:0] pda, pdb;
        pva = 0; pra = 0; pvb = 0; prb = 0; pda = 0; pdb = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pva && !pra) begin
                    check("hold_valid_a", rsp_valid_a, 1);
                    check("hold_data_a", rsp_data_a, pda);
                end else if (rsp_valid_a) begin
                    if (lat_q_a.size() == 0) check("unexpected_rsp_a", 1, 0);
                    else check("latency_a", cyc, lat_q_a.pop_front());
                end
                if (rsp_valid_a && rsp_ready_a) begin
                    if (exp_q_a.size() == 0) check("unexpected_data_a", 1, 0);
                    else check("rdata_a", rsp_data_a, exp_q_a.pop_front());
                end
                if (pvb && !prb) begin
                    check("hold_valid_b", rsp_valid_b, 1);
                    check("hold_data_b", rsp_data_b, pdb);
                end else if (rsp_valid_b) begin
                    if (lat_q_b.size() == 0) check("unexpected_rsp_b", 1, 0);
                    else check("latency_b", cyc, lat_q_b.pop_front());
                end
                if (rsp_valid_b && rsp_ready_b) begin
                    if (exp_q_b.size() == 0) check("unexpected_data_b", 1, 0);
                    else check("rdata_b", rsp_data_b, exp_q_b.pop_front());
                end
                if (mem_we_a) begin run_a++; wcnt_a++; end
                else run_a = 0;
                if (run_a > max_a) max_a = run_a;
            end
            pva = rsp_valid_a; pra = rsp_ready_a; pda = rsp_data_a;
            pvb = rsp_valid_b; prb = rsp_ready_b; pdb = rsp_data_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rsp_ready_a = 1'b1;
        req_valid_a = 0; req_we_a = 0; req_addr_a = 0; req_wdata_a = 0;
        req_valid_b = 0; req_we_b = 0; req_addr_b = 0; req_wdata_b = 0;
        repeat (3) step();
        @(negedge clk);
        check("rst_ready_a", req_ready_a, 0);
        check("rst_ready_b", req_ready_b, 0);
        check("rst_rsp_valid", {rsp_valid_a, rsp_valid_b}, 0);
        check("rst_mem_we", {mem_we_a, mem_we_b}, 0);
        check("rst_mem_addr", {mem_addr_a, mem_addr_b}, 0);
        check("rst_mem_d_a", mem_d_a, 0);
        check("rst_rsp_data_a", rsp_data_a, 0);
        check("rst_coll_cnt", coll_cnt, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_a", req_ready_a, 1);
        step();

        max_a = 0; wcnt_a = 0;
        for (int i = 0; i < 4; i++) do_pair(1, 1, 3'(i), 32'(15 - i), 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("wr_burst_run_a", max_a, 4);
        check("wr_burst_cnt_a", wcnt_a, 4);
        for (int i = 0; i < 4; i++) do_pair(1, 0, 3'(i), 0, 3, 0, 0, 0, 0, 0);
        drain();

        hold_b = 1'b1;
        for (int i = 0; i < 4; i++) do_pair(0, 0, 0, 0, 0, 1, 1, 3'(4 + i), 32'(11 - i), 0);
        for (int i = 0; i < 4; i++) do_pair(0, 0, 0, 0, 0, 1, 0, 3'(4 + i), 0, 3);
        drain();
        hold_b = 1'b0;
        step();

        do_pair(1, 1, 5, 99, 0, 1, 1, 5, 42, 0);
        @(negedge clk);
        check("ww_first_we_a", mem_we_a, 1);
        check("ww_first_d_a", mem_d_a, 99);
        check("ww_first_we_b", mem_we_b, 0);
        step();
        @(negedge clk);
        check("ww_second_we_b", mem_we_b, 1);
        check("ww_second_d_b", mem_d_b, 42);
        repeat (3) step();
        check("ww_coll_cnt", coll_cnt, 1);
        do_pair(1, 0, 5, 0, 3, 0, 0, 0, 0, 0);
        drain();

        do_pair(1, 1, 5, 77, 0, 1, 0, 5, 0, 4);
        drain();
        check("wr_coll_cnt", coll_cnt, 2);

        for (int i = 0; i < 300; i++) begin
            do_pair(1, 1, 3, 32'(1000 + i), 0, 1, 1, 3, 32'(2000 + i), 0);
            repeat (2) step();
        end
        check("sat_coll_cnt", coll_cnt, 255);
        do_pair(1, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        drain();

        do_pair(1, 0, 2, 0, 3, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b0;
        exp_q_a.delete();
        lat_q_a.delete();
        @(negedge clk);
        check("midrst_ready_a", req_ready_a, 0);
        step();
        @(negedge clk);
        check("midrst_rsp_valid_a", rsp_valid_a, 0);
        check("midrst_rsp_data_a", rsp_data_a, 0);
        check("midrst_mem", {mem_we_a, mem_addr_a, mem_we_b, mem_addr_b}, 0);
        check("midrst_coll_cnt", coll_cnt, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_ready_a", req_ready_a, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check("midrst_no_rsp_a", rsp_valid_a, 0);
        end
        check("final_queues_empty", exp_q_a.size() + exp_q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
